cmp_stream_window: RTL and testbench
====================================

Name: cmp_stream_window

Overview:
- Streaming, parametrised successor to the team's combinational n-bit comparator.
- Accepts (a,b) sample pairs over a valid/ready handshake and returns registered lesser/greater/equal flags.
- Supports a selectable signed or unsigned compare.
- Keeps per-window tallies of the three outcomes over WIN samples; sits between sample producers and monitor/statistics logic.

Parameters:
N, 16, operand width in bits (>=1)
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
WIN, 8, samples per statistics window (>=1)
CW, $clog2(WIN+1), tally width (derived, not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
clr  input  1  restart current window (zero running tallies)
in_valid  input  1  a/b valid
in_ready  output  1  block can accept a sample this cycle
a  input  N  operand A
b  input  N  operand B
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result beat
lesser  output  1  a<b for the beat
greater  output  1  a>b for the beat
equal  output  1  a==b for the beat
win_last  output  1  beat is the WIN-th sample of its window
win_lt  output  CW  lesser tally of last completed window
win_gt  output  CW  greater tally of last completed window
win_eq  output  CW  equal tally of last completed window

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-low; clock and reset ports are named clk and rst_n.
  - While rst_n=0 at a clk edge: out_valid, lesser, greater, equal, win_last, win_lt/gt/eq, the running tallies and the sample counter all clear to 0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-operation discards any held beat and the partial window.
- Handshake:
  - in_ready = rst_n & (!out_valid | out_ready), combinational.
  - Accept = in_valid & in_ready.
  - The output register holds one beat. Throughput is 1 sample/clk when out_ready=1.
  - While out_valid=1 and out_ready=0, every output holds stable and no sample is accepted.
  - out_valid falls after a handshake only if no new sample is accepted in the same cycle.
- Latency: a sample accepted at edge k appears on the outputs with out_valid=1 after edge k (1 cycle).
- Compare:
  - SIGNED=0: operands are compared as unsigned.
  - SIGNED=1: operands are compared as two's-complement.
  - Exactly one of lesser/greater/equal is 1 when out_valid=1; all three are 0 when out_valid=0 (cleared on drain).
- Window:
  - Internal sample counter scnt (0..WIN-1) and running tallies rlt/rgt/req (CW bits) increment per accepted sample.
  - On the accept where scnt==WIN-1:
    - The beat is tagged win_last=1.
    - win_lt/gt/eq load rlt/rgt/req plus the current sample's contribution. They update on the same edge the beat becomes visible and hold until the next window completes.
    - scnt and the running tallies return to 0.
  - win_lt + win_gt + win_eq == WIN always after the first completion.
  - WIN=1: every beat has win_last=1 and exactly one tally equals 1.
- clr:
  - Zeroes scnt and the running tallies. It does not affect win_* registers or a pending output beat.
  - clr with a simultaneous accept: the accepted sample counts as sample 1 of the new window. If WIN=1 it completes that window.
  - clr has no effect on the handshake.
- Tallies never overflow: CW holds WIN.

Test Plan:
- Reset, then N=16, SIGNED=0, WIN=4, out_ready=1; stream (5,3),(3,5),(7,7),(0,FFFF) -> beats G,L,E,L, 1 clk latency each; win_last on 4th beat; win_gt=1, win_lt=2, win_eq=1.
- SIGNED=1, N=8: (0x80,0x7F) -> lesser=1; (0xFF,0x00) -> lesser=1. Same vectors with SIGNED=0 -> greater=1 both.
- Back-pressure: hold out_ready=0 for 3 clks after beat 1 -> in_ready=0, outputs frozen, no sample lost; release -> beats 2..4 follow at 1/clk; tallies as in scenario 1.
- clr after 2 samples of WIN=4, then 4 more equal pairs -> win_eq=4, win_lt=win_gt=0; win_* unchanged until that completion.
- clr coincident with an accept, WIN=4 -> that sample counted as 1st; win_last on the 3rd following accept.
- rst_n=0 for 1 clk mid-window with out_valid=1 -> all outputs 0, in_ready=0 during reset; next window counts from 0 (win_last after 4 new samples).

Source files
------------

// File: rtl/cmp_stream_window.sv
// Streaming a/b comparator with a one-beat registered output stage and
// per-window tallies of lesser/greater/equal outcomes.
module cmp_stream_window #(
   parameter  int N      = 16,
   parameter  int SIGNED = 0,
   parameter  int WIN    = 8,
   localparam int CW     = $clog2(WIN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          lesser,
   output logic          greater,
   output logic          equal,
   output logic          win_last,
   output logic [CW-1:0] win_lt,
   output logic [CW-1:0] win_gt,
   output logic [CW-1:0] win_eq
);

   logic          out_valid_q, lesser_q, greater_q, equal_q, win_last_q;
   logic [CW-1:0] win_lt_q, win_gt_q, win_eq_q;
   logic [CW-1:0] rlt_q, rgt_q, req_q, scnt_q;
   logic [CW-1:0] rlt_d, rgt_d, req_d, scnt_b;
   logic          accept, lt_c, gt_c, eq_c, wrap;

   assign in_ready = rst_n & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      if (SIGNED != 0) begin
         lt_c = $signed(a) < $signed(b);
         gt_c = $signed(a) > $signed(b);
      end else begin
         lt_c = a < b;
         gt_c = a > b;
      end
      eq_c = (a == b);
      // clr restarts the window before the current sample is counted
      scnt_b = clr ? '0 : scnt_q;
      rlt_d  = (clr ? '0 : rlt_q) + CW'(lt_c);
      rgt_d  = (clr ? '0 : rgt_q) + CW'(gt_c);
      req_d  = (clr ? '0 : req_q) + CW'(eq_c);
      wrap   = (scnt_b == CW'(WIN - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         lesser_q    <= 1'b0;
         greater_q   <= 1'b0;
         equal_q     <= 1'b0;
         win_last_q  <= 1'b0;
         win_lt_q    <= '0;
         win_gt_q    <= '0;
         win_eq_q    <= '0;
         rlt_q       <= '0;
         rgt_q       <= '0;
         req_q       <= '0;
         scnt_q      <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            lesser_q    <= lt_c;
            greater_q   <= gt_c;
            equal_q     <= eq_c;
            win_last_q  <= wrap;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            lesser_q    <= 1'b0;
            greater_q   <= 1'b0;
            equal_q     <= 1'b0;
            win_last_q  <= 1'b0;
         end

         if (accept) begin
            if (wrap) begin
               win_lt_q <= rlt_d;
               win_gt_q <= rgt_d;
               win_eq_q <= req_d;
               rlt_q    <= '0;
               rgt_q    <= '0;
               req_q    <= '0;
               scnt_q   <= '0;
            end else begin
               rlt_q  <= rlt_d;
               rgt_q  <= rgt_d;
               req_q  <= req_d;
               scnt_q <= scnt_b + CW'(1);
            end
         end else if (clr) begin
            rlt_q  <= '0;
            rgt_q  <= '0;
            req_q  <= '0;
            scnt_q <= '0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign lesser    = lesser_q;
   assign greater   = greater_q;
   assign equal     = equal_q;
   assign win_last  = win_last_q;
   assign win_lt    = win_lt_q;
   assign win_gt    = win_gt_q;
   assign win_eq    = win_eq_q;

endmodule

// File: tb/tb_cmp_stream_window.sv
// Scoreboard bench for cmp_stream_window: 16-bit WIN=4 unsigned instance plus
// two 8-bit WIN=1 instances (signed and unsigned) fed the same vectors.
module tb_cmp_stream_window;

   localparam logic [2:0] L = 3'b100, G = 3'b010, E = 3'b001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [15:0] a = '0, b = '0;
   logic        in_ready, out_valid, lesser, greater, equal, win_last;
   logic [2:0]  win_lt, win_gt, win_eq;

   logic        v8 = 1'b0, clr8 = 1'b0, or8 = 1'b1;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ir_s, ov_s, lt_s, gt_s, eq_s, wl_s;
   logic        ir_u, ov_u, lt_u, gt_u, eq_u, wl_u;
   logic [0:0]  wlt_s, wgt_s, weq_s, wlt_u, wgt_u, weq_u;

   cmp_stream_window #(.N(16), .SIGNED(0), .WIN(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .lesser(lesser), .greater(greater), .equal(equal), .win_last(win_last),
      .win_lt(win_lt), .win_gt(win_gt), .win_eq(win_eq));

   cmp_stream_window #(.N(8), .SIGNED(1), .WIN(1)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .clr(clr8), .in_valid(v8), .in_ready(ir_s),
      .a(a8), .b(b8), .out_valid(ov_s), .out_ready(or8),
      .lesser(lt_s), .greater(gt_s), .equal(eq_s), .win_last(wl_s),
      .win_lt(wlt_s), .win_gt(wgt_s), .win_eq(weq_s));

   cmp_stream_window #(.N(8), .SIGNED(0), .WIN(1)) dut_u8 (
      .clk(clk), .rst_n(rst_n), .clr(clr8), .in_valid(v8), .in_ready(ir_u),
      .a(a8), .b(b8), .out_valid(ov_u), .out_ready(or8),
      .lesser(lt_u), .greater(gt_u), .equal(eq_u), .win_last(wl_u),
      .win_lt(wlt_u), .win_gt(wgt_u), .win_eq(weq_u));

   typedef struct packed {
      logic [2:0] f;
      logic       last;
      logic [2:0] wlt, wgt, weq;
   } beat_t;

   beat_t      q[$];
   logic [2:0] qs[$], qu[$];
   int unsigned vecs = 0, errs = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop expected beat whenever a result handshake is about to occur
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("main_spurious_beat", 64'(1), 64'(0));
         end else begin
            beat_t e;
            e = q.pop_front();
            chk("main_flags", 64'({lesser, greater, equal}), 64'(e.f));
            chk("main_win_last", 64'(win_last), 64'(e.last));
            chk("main_win_tally", 64'({win_lt, win_gt, win_eq}), 64'({e.wlt, e.wgt, e.weq}));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov_s && or8) begin
         if (qs.size() == 0) chk("s8_spurious_beat", 64'(1), 64'(0));
         else begin
            logic [2:0] e;
            e = qs.pop_front();
            chk("s8_flags", 64'({lt_s, gt_s, eq_s}), 64'(e));
            chk("s8_win", 64'({wl_s, wlt_s, wgt_s, weq_s}), 64'({1'b1, e}));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov_u && or8) begin
         if (qu.size() == 0) chk("u8_spurious_beat", 64'(1), 64'(0));
         else begin
            logic [2:0] e;
            e = qu.pop_front();
            chk("u8_flags", 64'({lt_u, gt_u, eq_u}), 64'(e));
            chk("u8_win", 64'({wl_u, wlt_u, wgt_u, weq_u}), 64'({1'b1, e}));
         end
      end
   end

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] f,
                        input logic last, input logic [2:0] wl, input logic [2:0] wg,
                        input logic [2:0] we, input logic c);
      a = av; b = bv; clr = c; in_valid = 1'b1;
      q.push_back('{f: f, last: last, wlt: wl, wgt: wg, weq: we});
   endtask

   task automatic wait_accept();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr = 1'b0;
      chk("latency_out_valid", 64'(out_valid), 64'(1));
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] f,
                       input logic last, input logic [2:0] wl, input logic [2:0] wg,
                       input logic [2:0] we, input logic c = 1'b0);
      issue(av, bv, f, last, wl, wg, we, c);
      wait_accept();
   endtask

   task automatic send8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] sexp, input logic [2:0] uexp);
      int n = 0;
      a8 = av; b8 = bv; v8 = 1'b1;
      qs.push_back(sexp);
      qu.push_back(uexp);
      while (!(ir_s && ir_u) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(ir_s && ir_u)) chk("accept8_timeout", 64'({ir_s, ir_u}), 64'(2'b11));
      @(posedge clk);
      #1;
      v8 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || qs.size() != 0 || qu.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("queues_empty", 64'(q.size() + qs.size() + qu.size()), 64'(0));
   endtask

   initial begin
      // reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_outputs", 64'({out_valid, lesser, greater, equal, win_last}), 64'(0));
      chk("reset_tallies", 64'({win_lt, win_gt, win_eq}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic window of four
      send(16'd5, 16'd3,    G, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd3, 16'd5,    L, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd7, 16'd7,    E, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd0, 16'hFFFF, L, 1'b1, 3'd2, 3'd1, 3'd1);
      @(posedge clk);
      @(negedge clk);
      chk("drain_clears", 64'({out_valid, lesser, greater, equal, win_last}), 64'(0));
      chk("tally_hold_after_drain", 64'({win_lt, win_gt, win_eq}), 64'({3'd2, 3'd1, 3'd1}));

      // back-pressure after first beat
      @(posedge clk); #1;
      send(16'd5, 16'd3, G, 1'b0, 3'd2, 3'd1, 3'd1);
      out_ready = 1'b0;
      issue(16'd3, 16'd5, L, 1'b0, 3'd2, 3'd1, 3'd1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_frozen", 64'({out_valid, lesser, greater, equal, win_last}), 64'(5'b1_010_0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_accept();
      send(16'd7, 16'd7,    E, 1'b0, 3'd2, 3'd1, 3'd1);
      send(16'd0, 16'hFFFF, L, 1'b1, 3'd2, 3'd1, 3'd1);

      // standalone clr after two samples
      send(16'd1, 16'd2, L, 1'b0, 3'd2, 3'd1, 3'd1);
      send(16'd2, 16'd1, G, 1'b0, 3'd2, 3'd1, 3'd1);
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_keeps_win", 64'({win_lt, win_gt, win_eq}), 64'({3'd2, 3'd1, 3'd1}));
      send(16'd9, 16'd9, E, 1'b0, 3'd2, 3'd1, 3'd1);
      send(16'd9, 16'd9, E, 1'b0, 3'd2, 3'd1, 3'd1);
      send(16'd9, 16'd9, E, 1'b0, 3'd2, 3'd1, 3'd1);
      send(16'd9, 16'd9, E, 1'b1, 3'd0, 3'd0, 3'd4);

      // clr coincident with an accept: that sample opens the new window
      send(16'd1, 16'd2, L, 1'b0, 3'd0, 3'd0, 3'd4);
      send(16'd3, 16'd3, E, 1'b0, 3'd0, 3'd0, 3'd4, 1'b1);
      send(16'd4, 16'd1, G, 1'b0, 3'd0, 3'd0, 3'd4);
      send(16'd1, 16'd4, L, 1'b0, 3'd0, 3'd0, 3'd4);
      send(16'd2, 16'd2, E, 1'b1, 3'd1, 3'd1, 3'd2);

      // reset mid-window with a beat held
      send(16'd5, 16'd3, G, 1'b0, 3'd1, 3'd1, 3'd2);
      send(16'd3, 16'd5, L, 1'b0, 3'd1, 3'd1, 3'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      chk("midreset_outputs", 64'({out_valid, lesser, greater, equal, win_last}), 64'(0));
      chk("midreset_tallies", 64'({win_lt, win_gt, win_eq}), 64'(0));
      send(16'd1, 16'd1, E, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd1, 16'd1, E, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd2, 16'd1, G, 1'b0, 3'd0, 3'd0, 3'd0);
      send(16'd1, 16'd2, L, 1'b1, 3'd1, 3'd1, 3'd2);

      // signed vs unsigned 8-bit, WIN=1
      send8(8'h80, 8'h7F, L, G);
      send8(8'hFF, 8'h00, L, G);
      send8(8'h7F, 8'h80, G, L);
      send8(8'h05, 8'h05, E, E);
      send8(8'hFE, 8'hFF, L, L);

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
